// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared definitions for the decoder scan sequencer: FSM state encoding,
//   default widths and the last-select-code helper.
package decoder_pkg;

  localparam int DWELL_W_DEF = 8;
  localparam int SEL_W_DEF   = 3;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t ST_IDLE = 2'd0;
  localparam scan_state_t ST_RUN  = 2'd1;
  localparam scan_state_t ST_DONE = 2'd2;

  // Highest select code for a given select width.
  function automatic int sel_last(input int sel_w);
    return (1 << sel_w) - 1;
  endfunction

  localparam int SEL_LAST = sel_last(SEL_W_DEF);

endpackage

// File: rtl/decoder_scan_ctrl_dwell_counter.sv
// dwell_counter
//   Loadable down-counter that times how long each select code is held.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load       : load load_val this cycle (wins over dec)
//     load_val   : value to load
//     dec        : decrement enable; the count never drops below 1
//     expire     : count == 1, i.e. last cycle of the current dwell
module dwell_counter
  import decoder_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count > DWELL_W'(1))) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == DWELL_W'(1));

endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Sequencer that drives a 3-to-8 decoder's En/I through codes 0..last,
//   holding each code for a latched dwell, in single-pass or continuous mode.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     start       : scan request, honoured only in IDLE
//     stop        : abort, honoured in every state (beats start and expiry)
//     mode        : 0 single pass, 1 continuous (latched at accepted start)
//     dwell       : cycles per code, 0 treated as 1 (latched at accepted start)
//     En, I       : registered decoder enable / select
//     busy        : high while scanning
//     step_tick   : pulse on the first cycle of each new code (not the first
//                   code of a pass)
//     done        : pulse for the single cycle after a single pass finishes
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | outputs parked, waiting for start
//   RUN   | En high, stepping I every D cycles
//   DONE  | one-cycle completion pulse, then back to IDLE
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               En,
  output logic [SEL_W-1:0]   I,
  output logic               busy,
  output logic               step_tick,
  output logic               done
);

  localparam int LAST_INT = sel_last(SEL_W);
  localparam logic [SEL_W-1:0] LAST = LAST_INT[SEL_W-1:0];

  scan_state_t        state;
  logic               mode_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_eff;
  logic               accept;
  logic               advance;
  logic               cnt_load;
  logic [DWELL_W-1:0] cnt_load_val;
  logic               expire;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign accept    = (state == ST_IDLE) && start && !stop;
  // Expiry that moves on to another code (a step or a wrap) rather than ending.
  assign advance   = (state == ST_RUN) && !stop && expire && ((I != LAST) || mode_q);

  assign cnt_load     = accept || advance;
  assign cnt_load_val = accept ? dwell_eff : dwell_q;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (state == ST_RUN),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      En        <= 1'b0;
      I         <= '0;
      step_tick <= 1'b0;
      done      <= 1'b0;
      mode_q    <= 1'b0;
      dwell_q   <= '0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          En <= 1'b0;
          I  <= '0;
          if (accept) begin
            state   <= ST_RUN;
            En      <= 1'b1;
            mode_q  <= mode;
            dwell_q <= dwell_eff;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            En    <= 1'b0;
            I     <= '0;
          end else if (expire) begin
            if (I != LAST) begin
              I         <= I + 1'b1;
              step_tick <= 1'b1;
            end else if (mode_q) begin
              I         <= '0;
              step_tick <= 1'b1;
            end else begin
              state <= ST_DONE;
              En    <= 1'b0;
              I     <= '0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          En    <= 1'b0;
          I     <= '0;
        end
        default: begin
          state <= ST_IDLE;
          En    <= 1'b0;
          I     <= '0;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl
//   Scoreboarded bench: each scenario pushes the expected per-cycle output
//   word {En, busy, step_tick, done, I} and pops/compares after every edge.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] dwell;
  logic       En;
  logic [2:0] I;
  logic       busy;
  logic       step_tick;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  logic [6:0] exp_q[$];

  decoder_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .En        (En),
    .I         (I),
    .busy      (busy),
    .step_tick (step_tick),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {En, busy, step_tick, done, I};
  endfunction

  // Expected words for n_run cycles of RUN with dwell d, optionally followed
  // by the DONE cycle and one IDLE cycle.
  function automatic void push_scan(input int d, input int n_run, input bit with_end);
    for (int j = 0; j < n_run; j++) begin
      logic [2:0] code;
      logic       tick;
      code = 3'((j / d) % 8);
      tick = (j > 0) && ((j % d) == 0);
      exp_q.push_back({1'b1, 1'b1, tick, 1'b0, code});
    end
    if (with_end) begin
      exp_q.push_back(7'b0001_000);
      exp_q.push_back(7'b0000_000);
    end
  endfunction

  task automatic test_reset();
    logic [6:0] got, want;
    rst = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b1; dwell = 8'd4;
    repeat (2) @(posedge clk);
    exp_q.push_back(7'b0);
    @(negedge clk);
    got = outs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset: got %b required %b", got, want);
    end
    rst = 1'b0; start = 1'b0; mode = 1'b0; dwell = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_single_d1();
    logic [6:0] got, want;
    int c = 0;
    int ticks = 0;
    push_scan(1, 8, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = (c == 0); stop = 1'b0; mode = 1'b0; dwell = 8'd0;
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (step_tick === 1'b1) ticks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single_d1 cyc %0d: got %b required %b", c, got, want);
      end
      c++;
    end
    vectors++;
    if (ticks != 7) begin
      errors++;
      $display("FAIL single_d1 tick count: got %0d required 7", ticks);
    end
  endtask

  task automatic test_single_d3();
    logic [6:0] got, want;
    int c = 0;
    push_scan(3, 24, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = (c == 0); stop = 1'b0; mode = 1'b0; dwell = 8'd3;
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL single_d3 cyc %0d: got %b required %b", c, got, want);
      end
      c++;
    end
  endtask

  task automatic test_continuous();
    logic [6:0] got, want;
    int c = 0;
    push_scan(2, 36, 0);
    exp_q.push_back(7'b0);
    exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = (c == 0); stop = (c == 36); mode = 1'b1; dwell = 8'd2;
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL continuous cyc %0d: got %b required %b", c, got, want);
      end
      c++;
    end
  endtask

  // Stop lands on the last dwell cycle of I=4, so it also beats the expiry.
  task automatic test_stop();
    logic [6:0] got, want;
    int c = 0;
    push_scan(2, 10, 0);
    repeat (4) exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = (c == 0) || (c == 11) || (c == 12);
      stop  = (c == 10) || (c == 11) || (c == 12);
      mode = 1'b0; dwell = 8'd2;
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL stop cyc %0d: got %b required %b", c, got, want);
      end
      c++;
    end
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] got, want;
    int c = 0;
    push_scan(1, 6, 0);
    exp_q.push_back(7'b0);
    push_scan(1, 8, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      rst = (c == 6); start = (c == 0) || (c == 7); stop = 1'b0;
      mode = 1'b0; dwell = 8'd1;
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got %b required %b", c, got, want);
      end
      c++;
    end
  endtask

  task automatic test_ignore_changes();
    logic [6:0] got, want;
    int c = 0;
    push_scan(2, 16, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = (c == 0) || (c == 5) || (c == 6); stop = 1'b0;
      mode  = (c >= 4) && (c < 9);
      dwell = (c >= 3) ? 8'd5 : 8'd2;
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL ignore_changes cyc %0d: got %b required %b", c, got, want);
      end
      c++;
    end
  endtask

  // start held high through RUN and DONE: restart is taken in the IDLE cycle.
  task automatic test_back_to_back();
    logic [6:0] got, want;
    int c = 0;
    push_scan(1, 8, 1);
    push_scan(1, 8, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = (c <= 10); stop = 1'b0; mode = 1'b0; dwell = 8'd1;
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %b required %b", c, got, want);
      end
      c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_d1();
    test_single_d3();
    test_continuous();
    test_stop();
    test_reset_mid();
    test_ignore_changes();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Upstream sequencer for the 3-to-8 decoder. On a start request it drives the decoder's `En` and 3-bit select `I` through codes 0..7, holding each code for a programmable number of clock cycles (dwell). It runs either a single pass or continuously, and can be aborted at any time. Its outputs connect directly to the decoder's `En`/`I` inputs, and it reports progress to the surrounding control logic.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the dwell count.
- `SEL_W`, default 3: select width. The last code is 2**SEL_W-1, which is 7 at the default.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: request a scan. Sampled only in IDLE.
- `stop` in 1: abort the scan. Sampled in every state.
- `mode` in 1: 0 = single pass, 1 = continuous. Latched at accepted start.
- `dwell` in DWELL_W: cycles per code. 0 is treated as 1. Latched at accepted start.
- `En` out 1: decoder enable. Registered.
- `I` out SEL_W: decoder select. Registered.
- `busy` out 1: high in RUN.
- `step_tick` out 1: one-cycle pulse in the first cycle of each new code after code 0 of a pass.
- `done` out 1: one-cycle pulse when a single pass completes.

## Operation
- Reset (`rst`=1 at an edge) puts every output in its reset value and the FSM in IDLE:
  - `En`=0, `I`=0, `busy`=0, `step_tick`=0, `done`=0.
  - Dwell counter = 0.
  - Latched mode/dwell = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `En`=0, `I`=0.
  - `start`=1 with `stop`=0 → RUN. Latch `mode`. Latch D = max(`dwell`,1). Load the counter with D.
  - `start` together with `stop` → stay in IDLE (stop wins).
- RUN:
  - `En`=1, `busy`=1.
  - The counter decrements each cycle.
  - When the counter is 1 and `I` < last code: `I` increments, the counter reloads D, and `step_tick` is 1 in the next cycle.
  - When the counter is 1 and `I` = last code:
    - mode 1: `I` wraps to 0, the counter reloads, and `step_tick` pulses.
    - mode 0: → DONE.
  - `stop`=1 → IDLE next cycle (`En`=0, `I`=0, no `done`). Stop has priority over expiry in the same cycle.
  - `start` is ignored while in RUN.
- DONE:
  - Lasts exactly one cycle. `En`=0, `I`=0, `done`=1, `busy`=0.
  - Always → IDLE.
  - `start` is ignored in DONE. A new scan needs `start` in IDLE, so the earliest restart is sampled one cycle after DONE.
- Counter arithmetic:
  - Unsigned, DWELL_W bits.
  - Never decrements below 1 while in RUN.
  - The maximum dwell is 2**DWELL_W-1 cycles.
- `dwell`/`mode` changes during RUN have no effect until the next accepted start.

## Timing
- Let `start` be accepted at edge n.
- From edge n+1, `I`=k holds for edges [n+1+kD, n+1+(k+1)D), with `En`=1 throughout.
- Single pass with D = 1 (dwell 0 or 1):
  - `I` steps every cycle, 0..7 over 8 cycles.
  - DONE at edge n+9.
  - IDLE at edge n+10.
- Single-pass length: 8·D cycles of `En`=1, then 1 DONE cycle.
- `step_tick` is coincident with the first cycle of the new `I` value. It does not pulse for `I`=0 at the start of a pass. It does pulse for `I`=0 after a wrap in continuous mode.
- `stop` latency: 1 cycle, in both RUN and DONE.
- `rst` overrides everything, including mid-scan. The outputs take their reset values at the next edge.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `decoder_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Localparam `SEL_LAST` = 2**SEL_W-1.
  - Default DWELL_W/SEL_W.
- Sub-module `dwell_counter`: loadable down-counter with inputs `load`, `load_val` and output `expire` (count==1). Instantiated once.
- FSM and `I` register live at top level.
- Intended for instantiation next to `decoder_3_8`, with `En`/`I` wired straight through.

## Test plan
- Reset, then `start` with `dwell`=0 and `mode`=0 → `I` = 0,1,…,7 on consecutive cycles with `En`=1. `done`=1 exactly one cycle after `I`=7. `En`=0, `I`=0 afterwards. 7 `step_tick` pulses.
- `dwell`=3, `mode`=0 → each code held 3 cycles. `En` high for 24 cycles. `done` at cycle 25 after acceptance.
- `mode`=1, `dwell`=2 → after `I`=7 for 2 cycles, `I` wraps to 0 with `step_tick`=1. `busy` stays 1. `done` never pulses.
- `stop` asserted while `I`=4 → next cycle `En`=0, `I`=0, `busy`=0, `done`=0. A `start` in the same cycle as a `stop` in IDLE → remains IDLE.
- `rst` pulsed mid-scan (`I`=5) → next edge all outputs at reset values. `start` re-issued → scan restarts at `I`=0.
- Change `dwell` from 2 to 5 mid-scan, and assert `start` during RUN → timing unchanged (still 2 cycles per code) and no restart.
